kmp_matcher: RTL and testbench

- Parametrised successor to the fixed 4-char, 8-bit text pattern counter.
- Runs a true Knuth-Morris-Pratt search over a text ROM, including on-chip construction of the failure (LPS) table.
- Takes any runtime pattern length up to PAT_MAX and a runtime text window, counts matches, and reports done/error to the top-level FSM.

---
 rtl/kmp_matcher.sv | 213 +++++++++++++++++++++
 tb/tb_kmp_matcher.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kmp_matcher.sv
// KMP pattern counter: loads a pattern ROM, builds its LPS table on chip, then scans a text ROM window.
// Define KMP_OVERLAP_EN to count overlapping matches; left undefined, matches are non-overlapping.
module kmp_matcher #(
  parameter int CHAR_W  = 8,
  parameter int PAT_MAX = 8,
  parameter int TXT_AW  = 14,
  parameter int CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       inicio,
  input  logic [$clog2(PAT_MAX):0]   pat_len,
  input  logic [TXT_AW-1:0]          txt_base,
  input  logic [TXT_AW-1:0]          txt_len,
  output logic [$clog2(PAT_MAX)-1:0] pat_addr,
  input  logic [CHAR_W-1:0]          pat_data,
  output logic [TXT_AW-1:0]          txt_addr,
  input  logic [CHAR_W-1:0]          txt_data,
  output logic [CNT_W-1:0]           instancias,
  output logic                       busy,
  output logic                       done,
  output logic                       error
);
  // state | meaning
  // IDLE  | waiting for inicio
  // LOAD  | reading pattern ROM into pat registers
  // BUILD | computing LPS table, one recurrence step per cycle
  // FETCH | text address driven, data arrives next cycle
  // CMP   | compare text char against pat[j], retries stay here
  // DONE  | result held until next inicio
  localparam int PW = $clog2(PAT_MAX);
  localparam int LW = PW + 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_BUILD, S_FETCH, S_CMP, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [LW-1:0]      plen_q, plen_d, k_q, k_d;
  logic [TXT_AW-1:0]  base_q, base_d, tlen_q, tlen_d, i_q, i_d, txt_addr_q, txt_addr_d;
  logic [PW-1:0]      len_q, len_d, j_q, j_d, pat_addr_q, pat_addr_d;
  logic [CHAR_W-1:0]  pat_q [PAT_MAX];
  logic [CHAR_W-1:0]  pat_d [PAT_MAX];
  logic [PW-1:0]      lps_q [PAT_MAX];
  logic [PW-1:0]      lps_d [PAT_MAX];
  logic [CHAR_W-1:0]  ch_q, ch_d, ch;
  logic               first_q, first_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TXT_AW-1:0]  i_inc;
  logic [PW-1:0]      restart;
  logic               adv;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      plen_q     <= '0;
      k_q        <= '0;
      base_q     <= '0;
      tlen_q     <= '0;
      i_q        <= '0;
      txt_addr_q <= '0;
      len_q      <= '0;
      j_q        <= '0;
      pat_addr_q <= '0;
      pat_q      <= '{default: '0};
      lps_q      <= '{default: '0};
      ch_q       <= '0;
      first_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      plen_q     <= plen_d;
      k_q        <= k_d;
      base_q     <= base_d;
      tlen_q     <= tlen_d;
      i_q        <= i_d;
      txt_addr_q <= txt_addr_d;
      len_q      <= len_d;
      j_q        <= j_d;
      pat_addr_q <= pat_addr_d;
      pat_q      <= pat_d;
      lps_q      <= lps_d;
      ch_q       <= ch_d;
      first_q    <= first_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    plen_d     = plen_q;
    k_d        = k_q;
    base_d     = base_q;
    tlen_d     = tlen_q;
    i_d        = i_q;
    txt_addr_d = txt_addr_q;
    len_d      = len_q;
    j_d        = j_q;
    pat_addr_d = pat_addr_q;
    pat_d      = pat_q;
    lps_d      = lps_q;
    ch_d       = ch_q;
    first_d    = first_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    adv        = 1'b0;
    i_inc      = i_q + TXT_AW'(1);
    // The first CMP cycle sees fresh ROM data; retries use the captured copy.
    ch         = first_q ? txt_data : ch_q;
`ifdef KMP_OVERLAP_EN
    restart    = lps_q[plen_q[PW-1:0] - PW'(1)];
`else
    restart    = '0;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (inicio) begin
          plen_d = pat_len;
          base_d = txt_base;
          tlen_d = txt_len;
          cnt_d  = '0;
          done_d = 1'b0;
          err_d  = 1'b0;
          i_d    = '0;
          j_d    = '0;
          if (pat_len == '0 || pat_len > LW'(PAT_MAX) || txt_len < TXT_AW'(pat_len)) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            busy_d     = 1'b1;
            pat_addr_d = '0;
            k_d        = '0;
            state_d    = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (k_q != '0) pat_d[k_q[PW-1:0] - PW'(1)] = pat_data;
        if (k_q == plen_q) begin
          k_d      = LW'(1);
          len_d    = '0;
          lps_d[0] = '0;
          state_d  = S_BUILD;
        end else begin
          k_d = k_q + LW'(1);
          if (k_q + LW'(1) < plen_q) pat_addr_d = k_q[PW-1:0] + PW'(1);
        end
      end
      S_BUILD: begin
        if (k_q == plen_q) begin
          txt_addr_d = base_q + i_q;
          state_d    = S_FETCH;
        end else if (pat_q[k_q[PW-1:0]] == pat_q[len_q]) begin
          lps_d[k_q[PW-1:0]] = len_q + PW'(1);
          len_d = len_q + PW'(1);
          k_d   = k_q + LW'(1);
        end else if (len_q != '0) begin
          len_d = lps_q[len_q - PW'(1)];
        end else begin
          lps_d[k_q[PW-1:0]] = '0;
          k_d = k_q + LW'(1);
        end
      end
      S_FETCH: begin
        first_d = 1'b1;
        state_d = S_CMP;
      end
      S_CMP: begin
        first_d = 1'b0;
        if (first_q) ch_d = txt_data;
        if (ch == pat_q[j_q]) begin
          if (LW'(j_q) == plen_q - LW'(1)) begin
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
            j_d = restart;
          end else begin
            j_d = j_q + PW'(1);
          end
          adv = 1'b1;
        end else if (j_q != '0) begin
          j_d = lps_q[j_q - PW'(1)];
        end else begin
          adv = 1'b1;
        end
        if (adv) begin
          i_d = i_inc;
          if (i_inc == tlen_q) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            txt_addr_d = base_q + i_inc;
            state_d    = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign pat_addr   = pat_addr_q;
  assign txt_addr   = txt_addr_q;
  assign instancias = cnt_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = err_q;
endmodule

// File: tb/tb_kmp_matcher.sv
// Bench for kmp_matcher: synchronous ROM models, a direct substring-count reference and scenario tasks.
module tb_kmp_matcher;
  localparam int AW   = 14;
  localparam int MASK = (1 << AW) - 1;

  logic          clk = 1'b0, rst = 1'b0, inicio = 1'b0;
  logic [3:0]    pat_len = '0;
  logic [AW-1:0] txt_base = '0, txt_len = '0;
  logic [2:0]    pat_addr;
  logic [7:0]    pat_data;
  logic [AW-1:0] txt_addr;
  logic [7:0]    txt_data;
  logic [7:0]    instancias;
  logic          busy, done, error;

  int checks = 0, errors = 0;
  logic [7:0] pat_rom [8];
  logic [7:0] txt_rom [1 << AW];

  bit            rec_en = 1'b0;
  logic [AW-1:0] rec_prev = '0;
  logic [AW-1:0] rec_q [$];

  kmp_matcher dut (
    .clk(clk), .rst(rst), .inicio(inicio), .pat_len(pat_len),
    .txt_base(txt_base), .txt_len(txt_len), .pat_addr(pat_addr), .pat_data(pat_data),
    .txt_addr(txt_addr), .txt_data(txt_data), .instancias(instancias),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    pat_data <= pat_rom[pat_addr];
    txt_data <= txt_rom[txt_addr];
  end

  always @(negedge clk) begin
    if (rec_en) begin
      if (txt_addr !== rec_prev) rec_q.push_back(txt_addr);
      rec_prev = txt_addr;
    end
  end

  // Counts occurrences by direct comparison at every text position.
  function automatic int model_count(input int plen, input int base, input int tlen);
    int cnt = 0;
    int pos = 0;
    while (pos + plen <= tlen) begin
      bit m = 1'b1;
      for (int k = 0; k < plen; k++)
        if (txt_rom[(base + pos + k) & MASK] != pat_rom[k]) m = 1'b0;
      if (m) begin
        cnt++;
`ifdef KMP_OVERLAP_EN
        pos++;
`else
        pos += plen;
`endif
      end else begin
        pos++;
      end
    end
    return (cnt > 255) ? 255 : cnt;
  endfunction

  task automatic set_pat(input string s);
    for (int k = 0; k < s.len(); k++) pat_rom[k] = s[k];
  endtask

  task automatic set_txt(input int base, input string s);
    for (int k = 0; k < s.len(); k++) txt_rom[(base + k) & MASK] = s[k];
  endtask

  task automatic start(input int plen, input int base, input int tlen);
    @(negedge clk);
    pat_len  = plen[3:0];
    txt_base = base[AW-1:0];
    txt_len  = tlen[AW-1:0];
    inicio   = 1'b1;
    @(negedge clk);
    inicio   = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int c = 0; c < 20000; c++) begin
      if (done === 1'b1) return;
      @(negedge clk);
    end
    checks++; errors++;
    $display("FAIL %s: done never rose within 20000 cycles", name);
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({instancias, busy, done, error, pat_addr, txt_addr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: cnt=%0d busy=%b done=%b err=%b paddr=%0d taddr=%0d required all 0",
               instancias, busy, done, error, pat_addr, txt_addr);
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, error} !== 3'b000) begin
      errors++;
      $display("FAIL reset_idle: busy/done/err=%b required 000", {busy, done, error});
    end
  endtask

  task automatic test_abab;
    int exp;
`ifdef KMP_OVERLAP_EN
    exp = 3;
`else
    exp = 2;
`endif
    set_pat("ABAB"); set_txt(0, "ABABABAB");
    start(4, 0, 8);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL abab_busy: busy=%b done=%b required 1 0", busy, done);
    end
    wait_done("abab");
    checks++;
    if (instancias !== exp[7:0] || error !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abab_count: cnt=%0d err=%b busy=%b required %0d 0 0", instancias, error, busy, exp);
    end
  endtask

  task automatic test_aaba;
    int exp;
`ifdef KMP_OVERLAP_EN
    exp = 3;
`else
    exp = 2;
`endif
    set_pat("AABA"); set_txt(100, "AABAACAADAABAABA");
    start(4, 100, 16);
    wait_done("aaba");
    checks++;
    if (instancias !== exp[7:0] || error !== 1'b0) begin
      errors++; $display("FAIL aaba_count: cnt=%0d err=%b required %0d 0", instancias, error, exp);
    end
  endtask

  task automatic test_errors;
    start(0, 0, 8);
    checks++;
    if ({done, error, busy} !== 3'b110 || instancias !== 8'd0) begin
      errors++;
      $display("FAIL err_len0: done/err/busy=%b cnt=%0d required 110 0", {done, error, busy}, instancias);
    end
    start(5, 0, 3);
    checks++;
    if ({done, error, busy} !== 3'b110) begin
      errors++; $display("FAIL err_short_text: done/err/busy=%b required 110", {done, error, busy});
    end
    start(9, 0, 20);
    checks++;
    if ({done, error, busy} !== 3'b110) begin
      errors++; $display("FAIL err_too_long: done/err/busy=%b required 110", {done, error, busy});
    end
    start(8, 0, 8);
    checks++;
    if ({done, error, busy} !== 3'b001) begin
      errors++; $display("FAIL max_len_accept: done/err/busy=%b required 001", {done, error, busy});
    end
    wait_done("max_len");
  endtask

  task automatic test_saturate;
    set_pat("A");
    for (int k = 0; k < 300; k++) txt_rom[1000 + k] = "A";
    start(1, 1000, 300);
    wait_done("saturate");
    checks++;
    if (instancias !== 8'd255) begin
      errors++; $display("FAIL saturate: cnt=%0d required 255", instancias);
    end
  endtask

  task automatic test_wrap;
    logic [AW-1:0] exp_a [4];
    exp_a[0] = 14'd16382; exp_a[1] = 14'd16383; exp_a[2] = 14'd0; exp_a[3] = 14'd1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    rec_q.delete(); rec_prev = '0; rec_en = 1'b1;
    set_pat("AB"); set_txt(16382, "ABAB");
    start(2, 16382, 4);
    wait_done("wrap");
    rec_en = 1'b0;
    checks++;
    if (rec_q.size() != 4) begin
      errors++; $display("FAIL wrap_fetches: got %0d addresses required 4", rec_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (rec_q[k] !== exp_a[k]) begin
          errors++; $display("FAIL wrap_addr%0d: got %0d required %0d", k, rec_q[k], exp_a[k]);
        end
      end
    end
    checks++;
    if (instancias !== 8'd2) begin
      errors++; $display("FAIL wrap_count: cnt=%0d required 2", instancias);
    end
  endtask

  task automatic test_busy_ignore;
    int base = 3000;
    int exp;
    set_pat("AB");
    for (int k = 0; k < 40; k++) txt_rom[base + k] = ($urandom_range(0, 1) != 0) ? "A" : "B";
    exp = model_count(2, base, 40);
    start(2, base, 40);
    repeat (12) @(negedge clk);
    pat_len = 4'd0; inicio = 1'b1;
    @(negedge clk); inicio = 1'b0;
    wait_done("busy_ignore");
    checks++;
    if (instancias !== exp[7:0] || error !== 1'b0) begin
      errors++;
      $display("FAIL busy_ignore: cnt=%0d err=%b required %0d 0", instancias, error, exp);
    end
  endtask

  task automatic test_reset_mid_build;
    int exp;
    set_pat("ABCABCAB");
    for (int k = 0; k < 50; k++) txt_rom[500 + k] = (k % 3 == 0) ? "A" : (k % 3 == 1) ? "B" : "C";
    exp = model_count(8, 500, 50);
    start(8, 500, 50);
    repeat (11) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({instancias, busy, done, error, pat_addr, txt_addr} !== '0) begin
      errors++;
      $display("FAIL midbuild_reset: cnt=%0d busy=%b done=%b err=%b paddr=%0d taddr=%0d required all 0",
               instancias, busy, done, error, pat_addr, txt_addr);
    end
    @(negedge clk); rst = 1'b1;
    start(8, 500, 50);
    wait_done("rerun");
    checks++;
    if (instancias !== exp[7:0] || error !== 1'b0) begin
      errors++; $display("FAIL rerun_count: cnt=%0d err=%b required %0d 0", instancias, error, exp);
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 10; n++) begin
      int plen = $urandom_range(1, 8);
      int tlen = $urandom_range(plen, 64);
      int base = $urandom_range(0, MASK);
      int exp;
      for (int k = 0; k < plen; k++) pat_rom[k] = ($urandom_range(0, 1) != 0) ? "A" : "B";
      for (int k = 0; k < tlen; k++) txt_rom[(base + k) & MASK] = ($urandom_range(0, 2) != 0) ? "A" : "B";
      exp = model_count(plen, base, tlen);
      start(plen, base, tlen);
      wait_done("random");
      checks++;
      if (instancias !== exp[7:0] || error !== 1'b0 || done !== 1'b1) begin
        errors++;
        $display("FAIL random%0d: plen=%0d tlen=%0d base=%0d cnt=%0d err=%b required %0d 0",
                 n, plen, tlen, base, instancias, error, exp);
      end
    end
  endtask

  initial begin
    for (int k = 0; k <= MASK; k++) txt_rom[k] = 8'h00;
    for (int k = 0; k < 8; k++) pat_rom[k] = 8'h00;
    test_reset();
    test_abab();
    test_aaba();
    test_errors();
    test_saturate();
    test_wrap();
    test_busy_ignore();
    test_reset_mid_build();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
